// File: rtl/sum_pkg.sv
// Shared definitions for the shared-adder front end: default latency,
// tag sizing and tag-to-strobe decoding.
package sum_pkg;

    localparam int ADD_LAT_DEFAULT = 4;
    localparam int MAX_NREQ        = 8;
    localparam int MAX_TAG_W       = 3;

    // Width of a requester index; never narrower than one bit.
    function automatic int tag_width(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

    // Decode a requester tag into a one-hot strobe vector.
    function automatic logic [MAX_NREQ-1:0] onehot(input logic [MAX_TAG_W-1:0] tag);
        logic [MAX_NREQ-1:0] vec;
        vec      = '0;
        vec[tag] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or above the
// pointer (wrapping) and moves the pointer just past each accepted grant.
module rr_arbiter
    import sum_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int TAG_W = tag_width(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             advance,
    output logic [NREQ-1:0]  grant,
    output logic [TAG_W-1:0] grant_idx,
    output logic             any
);

    logic [TAG_W-1:0] ptr_reg;

    // Scan from the farthest offset down so the nearest active request wins.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = int'(ptr_reg) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = TAG_W'(idx);
                any        = 1'b1;
            end
        end
    end

    // Pointer moves to the requester after the one just served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (advance) begin
            ptr_reg <= (grant_idx == TAG_W'(NREQ - 1)) ? '0 : grant_idx + TAG_W'(1);
        end
    end

endmodule

// File: rtl/sum_arbiter.sv
// Front end that shares one external pipelined adder between NREQ
// requesters. A shadow valid/tag pipeline follows each operation through
// the adder so its result can be steered back to the issuing requester.
module sum_arbiter
    import sum_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int ADD_LAT = ADD_LAT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  add_v_in,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    input  logic                  add_v_out,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  busy,
    output logic                  err
);

    localparam int TAG_W = tag_width(NREQ);
    // Stage 0 tracks the issue register; the remaining ADD_LAT+1 stages
    // follow the op from the adder's input sample to its v_out cycle.
    localparam int SH_STAGES = ADD_LAT + 2;
    localparam int LAST      = SH_STAGES - 1;
    localparam int MASK_W    = $clog2(ADD_LAT + 2);

    logic [NREQ-1:0]  arb_req;
    logic [NREQ-1:0]  arb_grant;
    logic [TAG_W-1:0] grant_idx;
    logic             accept;

    logic [WIDTH-1:0] a_slice [NREQ];
    logic [WIDTH-1:0] b_slice [NREQ];

    logic             add_v_in_reg;
    logic [WIDTH-1:0] add_a_reg;
    logic [WIDTH-1:0] add_b_reg;
    logic             add_cin_reg;

    logic [SH_STAGES-1:0] sh_valid_reg;
    logic [TAG_W-1:0]     sh_tag_reg [SH_STAGES];

    logic [NREQ-1:0]  rsp_valid_reg;
    logic [WIDTH-1:0] rsp_sum_reg;
    logic             rsp_cout_reg;
    logic             err_reg;
    logic [MASK_W-1:0] mask_cnt_reg;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign a_slice[gi] = req_a[gi*WIDTH +: WIDTH];
        assign b_slice[gi] = req_b[gi*WIDTH +: WIDTH];
    end

    // Nothing is granted while reset is held.
    assign arb_req   = req_valid & {NREQ{rst_n}};
    assign req_ready = arb_grant;

    rr_arbiter #(
        .NREQ  (NREQ),
        .TAG_W (TAG_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (arb_req),
        .advance   (accept),
        .grant     (arb_grant),
        .grant_idx (grant_idx),
        .any       (accept)
    );

    // Issue register: capture the granted requester's operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            add_v_in_reg <= 1'b0;
            add_a_reg    <= '0;
            add_b_reg    <= '0;
            add_cin_reg  <= 1'b0;
        end else begin
            add_v_in_reg <= accept;
            if (accept) begin
                add_a_reg   <= a_slice[grant_idx];
                add_b_reg   <= b_slice[grant_idx];
                add_cin_reg <= req_cin[grant_idx];
            end
        end
    end

    // Shadow pipeline: shift {valid, tag} every cycle alongside the adder.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_valid_reg <= '0;
            for (int s = 0; s < SH_STAGES; s++) begin
                sh_tag_reg[s] <= '0;
            end
        end else begin
            sh_valid_reg  <= {sh_valid_reg[LAST-1:0], accept};
            sh_tag_reg[0] <= grant_idx;
            for (int s = 1; s < SH_STAGES; s++) begin
                sh_tag_reg[s] <= sh_tag_reg[s-1];
            end
        end
    end

    // Response register: strobe the owning requester when its result lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_reg <= '0;
            rsp_sum_reg   <= '0;
            rsp_cout_reg  <= 1'b0;
        end else if (sh_valid_reg[LAST]) begin
            rsp_valid_reg <= NREQ'(onehot(MAX_TAG_W'(sh_tag_reg[LAST])));
            rsp_sum_reg   <= add_sum;
            rsp_cout_reg  <= add_cout;
        end else begin
            rsp_valid_reg <= '0;
        end
    end

    // Sticky error when the adder's valid disagrees with the shadow; ignored
    // right after reset while pre-reset ops may still drain out of the adder.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_reg      <= 1'b0;
            mask_cnt_reg <= MASK_W'(ADD_LAT + 1);
        end else begin
            if (mask_cnt_reg != '0) begin
                mask_cnt_reg <= mask_cnt_reg - MASK_W'(1);
            end else if (add_v_out != sh_valid_reg[LAST]) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign add_v_in  = add_v_in_reg;
    assign add_a     = add_a_reg;
    assign add_b     = add_b_reg;
    assign add_cin   = add_cin_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_cout  = rsp_cout_reg;
    assign err       = err_reg;
    assign busy      = add_v_in_reg | (|sh_valid_reg) | (|rsp_valid_reg);

endmodule

// File: tb/tb_sum_arbiter.sv
// Bench for sum_arbiter: an external adder model plus a transaction-level
// scoreboard (round-robin rule, queue of expected results with due cycle).
module tb_sum_arbiter;

    localparam int WIDTH   = 32;
    localparam int NREQ    = 4;
    localparam int ADD_LAT = 4;
    localparam int RSP_LAT = ADD_LAT + 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic                  add_v_in;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_cin;
    logic [WIDTH-1:0]      add_sum;
    logic                  add_cout;
    logic                  add_v_out;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  busy;
    logic                  err;

    always #5 clk = ~clk;

    sum_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_v_in(add_v_in), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .add_v_out(add_v_out),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .busy(busy), .err(err)
    );

    // External adder model: samples on each edge, result visible ADD_LAT
    // edges later. It has no reset, like the real shared adder.
    logic             inject = 1'b0;
    logic [ADD_LAT:0] pv = '0;
    logic [WIDTH:0]   pr [ADD_LAT+1];
    logic [WIDTH:0]   add_res;
    assign add_res = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    always @(posedge clk) begin
        pv    <= {pv[ADD_LAT-1:0], add_v_in};
        pr[0] <= add_res;
        for (int s = 1; s <= ADD_LAT; s++) pr[s] <= pr[s-1];
    end
    assign add_v_out = pv[ADD_LAT] | inject;
    assign add_sum   = pr[ADD_LAT][WIDTH-1:0];
    assign add_cout  = pr[ADD_LAT][WIDTH];

    typedef struct {
        int             tag;
        logic [WIDTH:0] res;
        int             due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   ptr_m = 0;
    int   last_grant = -1;
    int   rsp_count = 0;
    logic err_exp = 1'b0;

    function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
        for (int off = 0; off < NREQ; off++) begin
            if (v[(p + off) % NREQ]) return (p + off) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_op(input int i, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic c);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_cin[i] = c;
    endtask

    // One clock cycle with rst_n high: check the grant against the
    // round-robin rule, then check the response strobe against the queue.
    task automatic tick();
        int              g;
        exp_t            e;
        logic [NREQ-1:0] ready_exp;
        logic [NREQ-1:0] oh;
        logic            inj_now;
        #1;
        g = exp_grant(req_valid, ptr_m);
        ready_exp = '0;
        if (g >= 0) ready_exp[g] = 1'b1;
        checks++;
        if (req_ready !== ready_exp) begin
            failures++;
            $display("FAIL grant cyc=%0d req_ready=%b expected=%b", cyc, req_ready, ready_exp);
        end
        last_grant = g;
        if (g >= 0) begin
            e.tag = g;
            e.res = {1'b0, req_a[g*WIDTH +: WIDTH]} + {1'b0, req_b[g*WIDTH +: WIDTH]}
                    + {{WIDTH{1'b0}}, req_cin[g]};
            e.due = cyc + 1 + RSP_LAT;
            q.push_back(e);
            ptr_m = (g + 1) % NREQ;
        end
        inj_now = inject;
        @(posedge clk);
        cyc++;
        #1;
        if (inj_now) err_exp = 1'b1;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            oh = '0;
            oh[e.tag] = 1'b1;
            checks++;
            if (rsp_valid !== oh || rsp_sum !== e.res[WIDTH-1:0] || rsp_cout !== e.res[WIDTH]) begin
                failures++;
                $display("FAIL response cyc=%0d valid=%b sum=%h cout=%b expected valid=%b sum=%h cout=%b",
                         cyc, rsp_valid, rsp_sum, rsp_cout, oh, e.res[WIDTH-1:0], e.res[WIDTH]);
            end else begin
                $display("cyc=%0d rsp req=%0d sum=%h cout=%b", cyc, e.tag, rsp_sum, rsp_cout);
            end
            rsp_count++;
        end else begin
            checks++;
            if (rsp_valid !== '0) begin
                failures++;
                $display("FAIL idle_rsp cyc=%0d rsp_valid=%b expected=0", cyc, rsp_valid);
            end
        end
        checks++;
        if (err !== err_exp) begin
            failures++;
            $display("FAIL err cyc=%0d err=%b expected=%b", cyc, err, err_exp);
        end
        @(negedge clk);
    endtask

    // Idle until every outstanding result has come back (bounded).
    task automatic drain();
        int n = 0;
        req_valid = '0;
        while (q.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout outstanding=%0d expected=0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        #1;
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("FAIL reset_ready req_ready=%b expected=0", req_ready);
        end
        @(posedge clk);
        cyc++;
        #1;
        checks++;
        if (add_v_in !== 1'b0 || add_a !== '0 || add_b !== '0 || add_cin !== 1'b0 ||
            rsp_valid !== '0 || rsp_sum !== '0 || rsp_cout !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state v_in=%b a=%h b=%h cin=%b rsp_valid=%b sum=%h cout=%b err=%b busy=%b expected all 0",
                     add_v_in, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout, err, busy);
        end
        $display("cyc=%0d reset", cyc);
        rst_n = 1'b1;
        req_valid = '0;
        q.delete();
        ptr_m = 0;
        err_exp = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_op();
        set_op(2, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        req_valid = 4'b0100;
        tick();
        checks++;
        if (last_grant != 2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_accept grant=%0d busy=%b expected grant=2 busy=1", last_grant, busy);
        end
        rsp_count = 0;
        drain();
        checks++;
        if (rsp_count != 1 || rsp_sum !== 32'h0000_0100 || rsp_cout !== 1'b0) begin
            failures++;
            $display("FAIL single_result count=%0d sum=%h cout=%b expected 1 00000100 0", rsp_count, rsp_sum, rsp_cout);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy busy=%b expected=0", busy);
        end
    endtask

    task automatic test_all_four();
        int seq [8];
        for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'(i), 32'h10, 1'b0);
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            seq[c] = last_grant;
        end
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (seq[c] != c % NREQ) begin
                failures++;
                $display("FAIL rr_order slot=%0d grant=%0d expected=%0d", c, seq[c], c % NREQ);
            end
        end
        drain();
    endtask

    task automatic test_carry();
        int r = $urandom_range(0, NREQ - 1);
        set_op(r, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        req_valid = '0;
        req_valid[r] = 1'b1;
        tick();
        drain();
        checks++;
        if (rsp_sum !== 32'h0000_0000 || rsp_cout !== 1'b1) begin
            failures++;
            $display("FAIL carry sum=%h cout=%b expected 00000000 1", rsp_sum, rsp_cout);
        end
    endtask

    task automatic test_sparse_wrap();
        int exp_seq [3] = '{3, 1, 3};
        test_reset();
        set_op(1, 32'h1, 32'h2, 1'b0);
        set_op(3, 32'h3, 32'h4, 1'b1);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (last_grant != exp_seq[c]) begin
                failures++;
                $display("FAIL sparse_wrap slot=%0d grant=%0d expected=%0d", c, last_grant, exp_seq[c]);
            end
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_op(i, $urandom, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
                       1'($urandom_range(0, 1)));
            end
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            tick();
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom, 1'b0);
        req_valid = 4'b0111;
        for (int c = 0; c < 3; c++) tick();
        req_valid = '0;
        tick();
        tick();
        test_reset();
        rsp_count = 0;
        for (int c = 0; c < 10; c++) tick();
        checks++;
        if (rsp_count != 0) begin
            failures++;
            $display("FAIL midflight_discard responses=%0d expected=0", rsp_count);
        end
        set_op(1, 32'h1234_5678, 32'h1111_1111, 1'b1);
        req_valid = 4'b0010;
        tick();
        drain();
        checks++;
        if (rsp_count != 1 || rsp_sum !== 32'h2345_678A) begin
            failures++;
            $display("FAIL midflight_new count=%0d sum=%h expected 1 2345678a", rsp_count, rsp_sum);
        end
    endtask

    task automatic test_fault();
        req_valid = '0;
        for (int c = 0; c < ADD_LAT + 4; c++) tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL fault_sticky err=%b expected=1", err);
        end
        test_reset();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_cin = '0;
        @(negedge clk);
        test_reset();
        test_single_op();
        test_reset();
        test_all_four();
        test_carry();
        test_sparse_wrap();
        test_random();
        test_reset_midflight();
        test_fault();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
